// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL acquisition / lock-supervision controller.
package pll_pkg;

  localparam int unsigned BIT_COUNT_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } pll_state_e;

endpackage

// File: rtl/pll_lock_ctrl_abs_diff.sv
// Combinational unsigned distance |a - b|, formed as larger minus smaller so it never wraps.
module abs_diff #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o
);

  // Subtract the smaller operand from the larger one.
  always_comb begin
    if (a_i >= b_i) begin
      diff_o = a_i - b_i;
    end else begin
      diff_o = b_i - a_i;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL acquisition and lock supervisor: sequences loop-filter reset, watches the speed
// word for stability, declares lock, detects loss of lock, retries and flags failure.
module pll_lock_ctrl
  import pll_pkg::*;
#(
  parameter int unsigned BIT_COUNT     = BIT_COUNT_DEF,
  parameter int unsigned LOCK_WINDOW   = 16,
  parameter int unsigned LOCK_CYCLES   = 1024,
  parameter int unsigned UNLOCK_WINDOW = 64,
  parameter int unsigned ACQ_TIMEOUT   = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned HOLD_CYCLES   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [BIT_COUNT-1:0]               speed_var,
  output logic                               lf_rst,
  output logic                               locked,
  output logic                               lol,
  output logic                               fail,
  output logic [2:0]                         state,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int unsigned SW = $clog2(LOCK_CYCLES) + 1;
  localparam int unsigned TW = $clog2(ACQ_TIMEOUT) + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [SW-1:0]        STABLE_LIM = SW'(LOCK_CYCLES);
  localparam logic [SW-1:0]        STABLE_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]        TMO_LIM    = TW'(ACQ_TIMEOUT);
  localparam logic [TW-1:0]        TMO_ONE    = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]        HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_ONE   = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]        RETRY_LIM  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0]        RETRY_ONE  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [BIT_COUNT-1:0] LOCK_WIN   = BIT_COUNT'(LOCK_WINDOW);
  localparam logic [BIT_COUNT-1:0] UNLOCK_WIN = BIT_COUNT'(UNLOCK_WINDOW);

  pll_state_e           state_q, state_d;
  logic [BIT_COUNT-1:0] ref_q, ref_d, lock_ref_q, lock_ref_d;
  logic [SW-1:0]        stable_q, stable_d, stable_inc_s;
  logic [TW-1:0]        tmo_q, tmo_d, tmo_inc_s;
  logic [HW-1:0]        hold_q, hold_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 first_q, first_d;
  logic                 lol_q, lol_d;
  logic                 lf_rst_q, lf_rst_d, locked_q, locked_d, fail_q, fail_d;
  logic [BIT_COUNT-1:0] acq_diff_s, lock_diff_s;
  logic                 lock_hit_s;

  abs_diff #(.WIDTH(BIT_COUNT)) u_acq_diff (
    .a_i    (speed_var),
    .b_i    (ref_q),
    .diff_o (acq_diff_s)
  );

  abs_diff #(.WIDTH(BIT_COUNT)) u_lock_diff (
    .a_i    (speed_var),
    .b_i    (lock_ref_q),
    .diff_o (lock_diff_s)
  );

  // Saturating increments of the stability and timeout counters.
  always_comb begin
    if (stable_q == STABLE_LIM) begin
      stable_inc_s = stable_q;
    end else begin
      stable_inc_s = stable_q + STABLE_ONE;
    end
    if (tmo_q == TMO_LIM) begin
      tmo_inc_s = tmo_q;
    end else begin
      tmo_inc_s = tmo_q + TMO_ONE;
    end
  end

  assign lock_hit_s = (acq_diff_s <= LOCK_WIN) && (stable_inc_s == STABLE_LIM);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    lock_ref_d = lock_ref_q;
    stable_d   = stable_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    retry_d    = retry_q;
    lol_d      = lol_q;
    first_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          hold_d  = {HW{1'b0}};
          retry_d = {RW{1'b0}};
          lol_d   = 1'b0;
        end
        ST_RESET: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_ACQUIRE;
            first_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
        ST_ACQUIRE: begin
          if (first_q) begin
            ref_d    = speed_var;
            stable_d = {SW{1'b0}};
            tmo_d    = {TW{1'b0}};
          end else begin
            tmo_d = tmo_inc_s;
            if (acq_diff_s > LOCK_WIN) begin
              ref_d    = speed_var;
              stable_d = {SW{1'b0}};
            end else begin
              stable_d = stable_inc_s;
            end
            // Lock takes precedence over a timeout landing in the same cycle.
            if (lock_hit_s) begin
              state_d    = ST_LOCKED;
              lock_ref_d = speed_var;
            end else if (tmo_inc_s == TMO_LIM) begin
              if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + RETRY_ONE;
                hold_d  = {HW{1'b0}};
                state_d = ST_RESET;
              end else begin
                state_d = ST_FAIL;
              end
            end else begin
              state_d = ST_ACQUIRE;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_diff_s > UNLOCK_WIN) begin
            state_d = ST_ACQUIRE;
            first_d = 1'b1;
            lol_d   = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    case (state_d)
      ST_ACQUIRE, ST_LOCKED: lf_rst_d = 1'b0;
      default:               lf_rst_d = 1'b1;
    endcase
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAIL);
  end

  // Controller state, counters, references and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ref_q      <= {BIT_COUNT{1'b0}};
      lock_ref_q <= {BIT_COUNT{1'b0}};
      stable_q   <= {SW{1'b0}};
      tmo_q      <= {TW{1'b0}};
      hold_q     <= {HW{1'b0}};
      retry_q    <= {RW{1'b0}};
      first_q    <= 1'b0;
      lol_q      <= 1'b0;
      lf_rst_q   <= 1'b1;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      lock_ref_q <= lock_ref_d;
      stable_q   <= stable_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      retry_q    <= retry_d;
      first_q    <= first_d;
      lol_q      <= lol_d;
      lf_rst_q   <= lf_rst_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign state     = state_q;
  assign lf_rst    = lf_rst_q;
  assign locked    = locked_q;
  assign lol       = lol_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Randomised and directed bench for pll_lock_ctrl, checked against a cycle-age reference model.
module tb_pll_lock_ctrl;

  localparam int BC = 24;
  localparam int LC = 8;
  localparam int AT = 32;
  localparam int MR = 2;
  localparam int HC = 4;
  localparam int LW = 16;
  localparam int UW = 64;
  localparam int SPD_MAX = (1 << BC) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [BC-1:0] speed_var;
  logic          lf_rst, locked, lol, fail;
  logic [2:0]    state;
  logic [1:0]    retry_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: state number, cycles spent in it, references, run length, retries.
  int m_state, m_age, m_ref, m_lock_ref, m_run, m_retry;
  bit m_lol;

  pll_lock_ctrl #(
    .BIT_COUNT(BC), .LOCK_WINDOW(LW), .LOCK_CYCLES(LC), .UNLOCK_WINDOW(UW),
    .ACQ_TIMEOUT(AT), .MAX_RETRIES(MR), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .speed_var(speed_var),
    .lf_rst(lf_rst), .locked(locked), .lol(lol), .fail(fail),
    .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_age = 1; m_ref = 0; m_lock_ref = 0; m_run = 0; m_retry = 0; m_lol = 1'b0;
  endtask

  task automatic model_step(input bit en, input int spd);
    int nxt;
    nxt = m_state;
    if (!en) begin
      nxt = 0;
    end else begin
      case (m_state)
        0: begin nxt = 1; m_retry = 0; m_lol = 1'b0; end
        1: if (m_age == HC) nxt = 2;
        2: begin
          if (m_age == 1) begin
            m_ref = spd; m_run = 0;
          end else begin
            if (iabs(spd - m_ref) > LW) begin m_ref = spd; m_run = 0; end
            else m_run++;
            if (m_run == LC) begin
              nxt = 3; m_lock_ref = spd;
            end else if (m_age == AT + 1) begin
              if (m_retry < MR) begin m_retry++; nxt = 1; end
              else nxt = 4;
            end
          end
        end
        3: if (iabs(spd - m_lock_ref) > UW) begin nxt = 2; m_lol = 1'b1; end
        default: ;
      endcase
    end
    m_age   = (nxt == m_state) ? m_age + 1 : 1;
    m_state = nxt;
  endtask

  task automatic check_all();
    check_eq("state",     32'(state),     32'(m_state));
    check_eq("lf_rst",    32'(lf_rst),    32'(m_state == 0 || m_state == 1 || m_state == 4));
    check_eq("locked",    32'(locked),    32'(m_state == 3));
    check_eq("fail",      32'(fail),      32'(m_state == 4));
    check_eq("lol",       32'(lol),       32'(m_lol));
    check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  task automatic step(input bit en, input int spd);
    int s;
    s = (spd < 0) ? 0 : ((spd > SPD_MAX) ? SPD_MAX : spd);
    enable    = en;
    speed_var = s[BC-1:0];
    @(posedge clk);
    model_step(en, s);
    #1;
    check_all();
  endtask

  initial begin
    int base, lock_at, center, mode, spd;
    base = 8388608;
    rst_n = 1'b0; enable = 1'b0; speed_var = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;

    // Basic lock with a constant speed word; lock expected on the 14th edge after enable.
    lock_at = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1'b1, base);
      if (locked && lock_at == 0) lock_at = i;
    end
    check_eq("lock_latency", 32'(lock_at), 32'd14);
    check_eq("basic_state", 32'(state), 32'd3);

    // Window edge: speed alternates between base and base+16.
    step(1'b0, base);
    for (int i = 0; i < 24; i++) step(1'b1, base + ((i % 2) * 16));

    // Window edge: one +17 step part-way through acquisition.
    step(1'b0, base);
    for (int i = 0; i < 30; i++) step(1'b1, (i >= 8) ? base + 17 : base);
    check_eq("plus17_locked", 32'(locked), 32'd1);

    // Loss of lock: +64 holds, +65 drops, then relock with lol sticky.
    for (int i = 0; i < 5; i++) step(1'b1, base + 17 + 64);
    check_eq("edge64_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 14; i++) step(1'b1, base + 17 + 65);
    check_eq("relock_lol", 32'(lol), 32'd1);
    check_eq("relock_locked", 32'(locked), 32'd1);

    // Timeout with an enable drop mid-attempt, then the full retry run into FAIL.
    step(1'b0, base);
    for (int i = 0; i < 50; i++) step(1'b1, base + ((i % 2) * 100));
    step(1'b0, base);
    check_eq("drop_state", 32'(state), 32'd0);
    for (int i = 0; i < 130; i++) step(1'b1, base + ((i % 2) * 100));
    check_eq("fail_flag", 32'(fail), 32'd1);
    check_eq("fail_retry", 32'(retry_cnt), 32'd2);

    // Randomised phases: quiet, noisy and drifting speed words around random centres.
    center = base;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        mode = $urandom_range(0, 2);
        case ($urandom_range(0, 3))
          0: center = 5;
          1: center = SPD_MAX - 60;
          default: center = $urandom_range(0, SPD_MAX - 200);
        endcase
      end
      if (mode == 2 && i % 8 == 0) center = center + $urandom_range(0, 70);
      if (center > SPD_MAX - 60) center = SPD_MAX - 60;
      spd = center + ((mode == 1) ? $urandom_range(0, 40) : $urandom_range(0, 16));
      step($urandom_range(0, 199) != 0, spd);
    end

    // Asynchronous reset between edges while locked.
    step(1'b0, base);
    for (int i = 0; i < 20; i++) step(1'b1, base);
    check_eq("pre_areset_locked", 32'(locked), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("areset_locked", 32'(locked), 32'd0);
    check_eq("areset_lf_rst", 32'(lf_rst), 32'd1);
    check_eq("areset_state", 32'(state), 32'd0);
    check_all();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, base + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
